// File: rtl/alu_issue_seq.sv
// alu_issue_seq
// Multi-cycle issue sequencer that drives an external combinational
// MIPS-subset ALU. It fetches an instruction, presents it to the ALU together
// with the two-entry register file (regA = address 0, regB = address 1), then
// performs writeback, branch resolution and load/store access.
//
// Optional feature macro: ALU_ISSUE_OVF_TRAP_EN
//   defined   : add/sub/addi that overflow skip writeback and retire and halt
//   undefined : the overflow flag is ignored
module alu_issue_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] alu_instruction,
   output logic [31:0] alu_regA,
   output logic [31:0] alu_regB,
   input  logic [31:0] alu_result,
   input  logic [2:0]  alu_flags,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        retire,
   output logic        halt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_res;
   logic [2:0]  r_flg;
   logic [31:0] r_memData;
   logic [31:0] r_regA;
   logic [31:0] r_regB;
   logic        r_imemReq;
   logic        r_dmemReq;
   logic        r_dmemWe;
   logic        r_retire;
   logic        r_halt;

   // Instruction fields of the latched instruction register
   logic [5:0]  w_opcode;
   logic [5:0]  w_func;
   logic [15:0] w_imm;
   logic        w_rt0;
   logic        w_rd0;

   // Decode results
   logic        w_isRType;
   logic        w_funcOk;
   logic        w_opOk;
   logic        w_supported;
   logic        w_isLoad;
   logic        w_isStore;
   logic        w_isBeq;
   logic        w_isBne;
   logic        w_isImmAlu;
   logic        w_isSetLess;
   logic        w_isOvfOp;
   logic        w_trap;
   logic        w_writesReg;
   logic        w_destSel;
   logic [31:0] w_wbData;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_branchOffset;
   logic [31:0] w_branchTarget;
   logic        w_taken;
   logic [31:0] w_nextPc;
   logic        w_unusedFlag;

   assign w_opcode = r_ir[31:26];
   assign w_func   = r_ir[5:0];
   assign w_imm    = r_ir[15:0];
   assign w_rt0    = r_ir[16];
   assign w_rd0    = r_ir[11];

   // Classify the R-type function codes the ALU understands
   always_comb begin
      w_funcOk = 1'b0;
      case (w_func)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2A, 6'h2B: w_funcOk = 1'b1;
         default:      w_funcOk = 1'b0;
      endcase
   end

   // Classify the non-R-type opcodes the ALU understands
   always_comb begin
      w_opOk = 1'b0;
      case (w_opcode)
         6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
         6'h23, 6'h2B: w_opOk = 1'b1;
         default:      w_opOk = 1'b0;
      endcase
   end

   assign w_isRType   = (w_opcode == 6'h00);
   assign w_supported = w_isRType ? w_funcOk : w_opOk;
   assign w_isLoad    = (w_opcode == 6'h23);
   assign w_isStore   = (w_opcode == 6'h2B);
   assign w_isBeq     = (w_opcode == 6'h04);
   assign w_isBne     = (w_opcode == 6'h05);
   assign w_isImmAlu  = (w_opcode >= 6'h08) && (w_opcode <= 6'h0E);
   assign w_isSetLess = (w_isRType && ((w_func == 6'h2A) || (w_func == 6'h2B)))
                        || (w_opcode == 6'h0A) || (w_opcode == 6'h0B);
   assign w_isOvfOp   = (w_isRType && ((w_func == 6'h20) || (w_func == 6'h22)))
                        || (w_opcode == 6'h08);

   // The trap looks at the live ALU flag during EXEC so HALT is entered on the
   // same edge that latches flg_q.
`ifdef ALU_ISSUE_OVF_TRAP_EN
   assign w_trap = w_isOvfOp && alu_flags[0];
`else
   assign w_trap = 1'b0;
`endif

   // Only the architectural effect of the overflow flag is through the live
   // ALU input above; the latched copy is kept for completeness.
   assign w_unusedFlag = r_flg[0] ^ w_isOvfOp;

   assign w_writesReg = (w_isRType && w_funcOk) || w_isImmAlu || w_isLoad;
   assign w_destSel   = w_isRType ? w_rd0 : w_rt0;

   // Set-less-than results come from the negative flag rather than the sum
   assign w_wbData = w_isLoad    ? r_memData :
                     w_isSetLess ? {31'b0, r_flg[1]} :
                                   r_res;

   assign w_pcPlus4      = r_pc + 32'd4;
   assign w_branchOffset = {{14{w_imm[15]}}, w_imm, 2'b00};
   assign w_branchTarget = w_pcPlus4 + w_branchOffset;
   assign w_taken        = (w_isBeq && r_flg[2]) || (w_isBne && !r_flg[2]);
   assign w_nextPc       = w_taken ? w_branchTarget : w_pcPlus4;

   // Sequencer FSM: state, latched instruction/ALU outputs and the
   // registered handshake/status outputs all move together here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ir      <= 32'd0;
         r_res     <= 32'd0;
         r_flg     <= 3'd0;
         r_memData <= 32'd0;
         r_imemReq <= 1'b0;
         r_dmemReq <= 1'b0;
         r_dmemWe  <= 1'b0;
         r_retire  <= 1'b0;
         r_halt    <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_state   <= S_FETCH;
               r_imemReq <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_ir      <= imem_rdata;
                  r_imemReq <= 1'b0;
                  r_state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_res <= alu_result;
               r_flg <= alu_flags;
               if (!w_supported || w_trap) begin
                  r_state <= S_HALT;
                  r_halt  <= 1'b1;
               end else if (w_isLoad || w_isStore) begin
                  r_state   <= S_MEM;
                  r_dmemReq <= 1'b1;
                  r_dmemWe  <= w_isStore;
               end else begin
                  r_state  <= S_WB;
                  r_retire <= 1'b1;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  r_memData <= dmem_rdata;
                  r_dmemReq <= 1'b0;
                  r_dmemWe  <= 1'b0;
                  r_state   <= S_WB;
                  r_retire  <= 1'b1;
               end
            end
            S_WB: begin
               r_state   <= S_FETCH;
               r_imemReq <= 1'b1;
            end
            S_HALT: begin
               r_state <= S_HALT;
               r_halt  <= 1'b1;
            end
            default: begin
               r_state   <= S_HALT;
               r_halt    <= 1'b1;
               r_imemReq <= 1'b0;
               r_dmemReq <= 1'b0;
               r_dmemWe  <= 1'b0;
            end
         endcase
      end
   end

   // Program counter advances only on the edge that ends WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (r_state == S_WB) begin
         r_pc <= w_nextPc;
      end
   end

   // Two-entry register file, written only on the edge that ends WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regA <= 32'd0;
         r_regB <= 32'd0;
      end else if ((r_state == S_WB) && w_writesReg) begin
         if (w_destSel) begin
            r_regB <= w_wbData;
         end else begin
            r_regA <= w_wbData;
         end
      end
   end

   assign imem_req        = r_imemReq;
   assign imem_addr       = r_pc;
   assign alu_instruction = r_ir;
   assign alu_regA        = r_regA;
   assign alu_regB        = r_regB;
   assign dmem_req        = r_dmemReq;
   assign dmem_we         = r_dmemWe;
   assign dmem_addr       = r_res;
   assign dmem_wdata      = w_rt0 ? r_regB : r_regA;
   assign retire          = r_retire;
   assign halt            = r_halt;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Testbench for alu_issue_seq. The bench plays instruction memory, data
// memory and the ALU; ALU results are hand-computed per instruction.
module tb_alu_issue_seq;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] alu_instruction;
   logic [31:0] alu_regA;
   logic [31:0] alu_regB;
   logic [31:0] alu_result;
   logic [2:0]  alu_flags;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        retire;
   logic        halt;

   int checkCount = 0;
   int passCount  = 0;

   // Results of the last applyStimulus call
   int          cycles;
   int          retires;
   logic [31:0] dAddr;
   logic        dWe;
   logic [31:0] dWdata;

   alu_issue_seq dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .alu_instruction (alu_instruction),
      .alu_regA        (alu_regA),
      .alu_regB        (alu_regB),
      .alu_result      (alu_result),
      .alu_flags       (alu_flags),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .retire          (retire),
      .halt            (halt)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset the DUT for two cycles and release on a falling edge
   task automatic doReset();
      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      alu_result = 32'd0;
      alu_flags  = 3'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Run one instruction: zero-wait fetch ack, data ack after dWait wait
   // cycles. Counts cycles from the FETCH ack cycle up to the retire cycle
   // (or halt), then, if retired, steps one more cycle so WB has committed.
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] res,
                                input logic [2:0] flg, input int dWait,
                                input logic [31:0] dData);
      int  waitCnt;
      bit  done;
      cycles  = 0;
      retires = 0;
      dAddr   = 32'd0;
      dWe     = 1'b0;
      dWdata  = 32'd0;
      waitCnt = 0;
      done    = 1'b0;
      for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
      if (!imem_req) begin
         cycles = -1;
         return;
      end
      imem_ack   = 1'b1;
      imem_rdata = instr;
      alu_result = res;
      alu_flags  = flg;
      cycles     = 1;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         cycles++;
         if (retire) begin
            retires++;
            done = 1'b1;
         end else if (halt) begin
            done = 1'b1;
         end else if (dmem_req) begin
            dAddr  = dmem_addr;
            dWe    = dmem_we;
            dWdata = dmem_wdata;
            if (waitCnt == dWait) begin
               dmem_ack   = 1'b1;
               dmem_rdata = dData;
            end else begin
               waitCnt++;
            end
         end
      end
      if (!done) begin
         cycles = -1;
      end else if (!halt) begin
         @(negedge clk);
         if (retire) retires++;
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      alu_result = 32'd0;
      alu_flags  = 3'd0;
      @(negedge clk);
      checkCount++;
      if ({imem_req, dmem_req, dmem_we, retire, halt} !== 5'b0)
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {imem_req, dmem_req, dmem_we, retire, halt});
      else passCount++;
      checkCount++;
      if ({imem_addr, alu_regA, alu_regB, alu_instruction} !== 128'd0)
         $display("[TB] FAIL reset_regs: got %h %h %h %h expected zeros", imem_addr, alu_regA, alu_regB, alu_instruction);
      else passCount++;
      rst_n = 1'b1;
      #1;
      checkCount++;
      if (imem_req !== 1'b0)
         $display("[TB] FAIL idle_req: got %b expected 0", imem_req);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd0)
         $display("[TB] FAIL first_fetch: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
      else passCount++;
   endtask

   task automatic test_addi();
      applyStimulus(32'h2000_0005, 32'd5, 3'b000, 0, 32'd0);
      checkCount++;
      if (alu_regA !== 32'd5)
         $display("[TB] FAIL addi_regA: got %h expected 00000005", alu_regA);
      else passCount++;
      checkCount++;
      if (imem_addr !== 32'd4)
         $display("[TB] FAIL addi_pc: got %h expected 00000004", imem_addr);
      else passCount++;
      checkCount++;
      if (retires !== 1 || cycles !== 3)
         $display("[TB] FAIL addi_timing: got retires=%0d cycles=%0d expected 1 and 3", retires, cycles);
      else passCount++;
   endtask

   task automatic test_branch();
      // Taken: regB=7, regA=7, beq at pc 8 jumps to 8+4+12
      doReset();
      applyStimulus(32'h2001_0007, 32'd7, 3'b000, 0, 32'd0);
      applyStimulus(32'h2000_0007, 32'd7, 3'b000, 0, 32'd0);
      checkCount++;
      if (alu_regA !== 32'd7 || alu_regB !== 32'd7 || imem_addr !== 32'd8)
         $display("[TB] FAIL beq_setup: got A=%h B=%h pc=%h expected 7 7 8", alu_regA, alu_regB, imem_addr);
      else passCount++;
      applyStimulus(32'h1001_0003, 32'd0, 3'b100, 0, 32'd0);
      checkCount++;
      if (imem_addr !== 32'd24)
         $display("[TB] FAIL beq_taken_pc: got %h expected 00000018", imem_addr);
      else passCount++;
      checkCount++;
      if (alu_regA !== 32'd7 || alu_regB !== 32'd7 || retires !== 1)
         $display("[TB] FAIL beq_taken_regs: got A=%h B=%h retires=%0d expected 7 7 1", alu_regA, alu_regB, retires);
      else passCount++;
      // Not taken: regB=6
      doReset();
      applyStimulus(32'h2001_0006, 32'd6, 3'b000, 0, 32'd0);
      applyStimulus(32'h2000_0007, 32'd7, 3'b000, 0, 32'd0);
      applyStimulus(32'h1001_0003, 32'd1, 3'b000, 0, 32'd0);
      checkCount++;
      if (imem_addr !== 32'd12)
         $display("[TB] FAIL beq_nt_pc: got %h expected 0000000c", imem_addr);
      else passCount++;
      checkCount++;
      if (alu_regA !== 32'd7 || alu_regB !== 32'd6)
         $display("[TB] FAIL beq_nt_regs: got A=%h B=%h expected 7 6", alu_regA, alu_regB);
      else passCount++;
   endtask

   task automatic test_load_store();
      doReset();
      applyStimulus(32'h2000_0100, 32'h100, 3'b000, 0, 32'd0);
      // lw rt=1, 8(regA), data ack after two wait cycles
      applyStimulus(32'h8C01_0008, 32'h108, 3'b000, 2, 32'hDEAD_BEEF);
      checkCount++;
      if (dAddr !== 32'h108 || dWe !== 1'b0)
         $display("[TB] FAIL lw_addr: got addr=%h we=%b expected 00000108 0", dAddr, dWe);
      else passCount++;
      checkCount++;
      if (alu_regB !== 32'hDEAD_BEEF || alu_regA !== 32'h100)
         $display("[TB] FAIL lw_data: got A=%h B=%h expected 00000100 deadbeef", alu_regA, alu_regB);
      else passCount++;
      checkCount++;
      if (cycles !== 6 || retires !== 1 || imem_addr !== 32'd8)
         $display("[TB] FAIL lw_timing: got cycles=%0d retires=%0d pc=%h expected 6 1 8", cycles, retires, imem_addr);
      else passCount++;
      // sw rt=1, 4(regA), zero-wait
      applyStimulus(32'hAC01_0004, 32'h104, 3'b000, 0, 32'h0);
      checkCount++;
      if (dAddr !== 32'h104 || dWe !== 1'b1 || dWdata !== 32'hDEAD_BEEF)
         $display("[TB] FAIL sw_bus: got addr=%h we=%b wdata=%h expected 00000104 1 deadbeef", dAddr, dWe, dWdata);
      else passCount++;
      checkCount++;
      if (cycles !== 4 || alu_regA !== 32'h100 || alu_regB !== 32'hDEAD_BEEF || imem_addr !== 32'd12)
         $display("[TB] FAIL sw_state: got cycles=%0d A=%h B=%h pc=%h expected 4 100 deadbeef c", cycles, alu_regA, alu_regB, imem_addr);
      else passCount++;
   endtask

   task automatic test_set_less_and_bne();
      // sltu rd=0: written value is the negative flag, not the ALU sum
      applyStimulus(32'h0001_002B, 32'h2152_4211, 3'b010, 0, 32'd0);
      checkCount++;
      if (alu_regA !== 32'd1 || imem_addr !== 32'd16)
         $display("[TB] FAIL sltu_wb: got A=%h pc=%h expected 00000001 00000010", alu_regA, imem_addr);
      else passCount++;
      // bne with offset -1 taken: target = 16+4-4
      applyStimulus(32'h1401_FFFF, 32'h2152_4112, 3'b000, 0, 32'd0);
      checkCount++;
      if (imem_addr !== 32'd16 || alu_regA !== 32'd1 || cycles !== 3)
         $display("[TB] FAIL bne_back: got pc=%h A=%h cycles=%0d expected 10 1 3", imem_addr, alu_regA, cycles);
      else passCount++;
   endtask

   task automatic test_overflow();
      doReset();
      applyStimulus(32'h0000_0027, 32'hFFFF_FFFF, 3'b010, 0, 32'd0);
      applyStimulus(32'h0000_0042, 32'h7FFF_FFFF, 3'b000, 0, 32'd0);
      checkCount++;
      if (alu_regA !== 32'h7FFF_FFFF)
         $display("[TB] FAIL ovf_setup: got %h expected 7fffffff", alu_regA);
      else passCount++;
      applyStimulus(32'h0000_0820, 32'hFFFF_FFFE, 3'b011, 0, 32'd0);
`ifdef ALU_ISSUE_OVF_TRAP_EN
      checkCount++;
      if (halt !== 1'b1 || alu_regB !== 32'd0 || retires !== 0)
         $display("[TB] FAIL ovf_trap: got halt=%b B=%h retires=%0d expected 1 0 0", halt, alu_regB, retires);
      else passCount++;
`else
      checkCount++;
      if (halt !== 1'b0 || alu_regB !== 32'hFFFF_FFFE || retires !== 1)
         $display("[TB] FAIL ovf_wb: got halt=%b B=%h retires=%0d expected 0 fffffffe 1", halt, alu_regB, retires);
      else passCount++;
`endif
   endtask

   task automatic test_halt();
      doReset();
      applyStimulus(32'h0800_0000, 32'd0, 3'b000, 0, 32'd0);
      checkCount++;
      if (halt !== 1'b1 || retires !== 0 || cycles !== 3)
         $display("[TB] FAIL halt_enter: got halt=%b retires=%0d cycles=%0d expected 1 0 3", halt, retires, cycles);
      else passCount++;
      for (int i = 0; i < 4; i++) begin
         imem_ack   = i[0];
         dmem_ack   = ~i[0];
         imem_rdata = 32'h2000_0005;
         dmem_rdata = 32'h1234_5678;
         @(negedge clk);
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         checkCount++;
         if (imem_req !== 1'b0 || dmem_req !== 1'b0 || retire !== 1'b0 || halt !== 1'b1)
            $display("[TB] FAIL halt_hold%0d: got req=%b dreq=%b ret=%b halt=%b expected 0 0 0 1", i, imem_req, dmem_req, retire, halt);
         else passCount++;
      end
      checkCount++;
      if (alu_instruction !== 32'h0800_0000 || imem_addr !== 32'd0 || alu_regA !== 32'd0)
         $display("[TB] FAIL halt_frozen: got ir=%h pc=%h A=%h expected 08000000 0 0", alu_instruction, imem_addr, alu_regA);
      else passCount++;
   endtask

   task automatic test_reset_mid_fetch();
      doReset();
      applyStimulus(32'h2000_0005, 32'd5, 3'b000, 0, 32'd0);
      repeat (3) @(negedge clk);
      checkCount++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd4)
         $display("[TB] FAIL fetch_wait: got req=%b addr=%h expected 1 00000004", imem_req, imem_addr);
      else passCount++;
      #2;
      rst_n = 1'b0;
      #1;
      checkCount++;
      if (imem_req !== 1'b0 || imem_addr !== 32'd0 || alu_regA !== 32'd0 || alu_instruction !== 32'd0)
         $display("[TB] FAIL async_reset: got req=%b pc=%h A=%h ir=%h expected 0 0 0 0", imem_req, imem_addr, alu_regA, alu_instruction);
      else passCount++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkCount++;
      if (imem_req !== 1'b0)
         $display("[TB] FAIL restart_idle: got %b expected 0", imem_req);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd0)
         $display("[TB] FAIL restart_fetch: got req=%b addr=%h expected 1 0", imem_req, imem_addr);
      else passCount++;
   endtask

   // Run every scenario in order and report
   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_load_store();
      test_set_less_and_bne();
      test_overflow();
      test_halt();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
